led_ctrl: RTL

LED_CTRL -- requirements
Module: led_ctrl

---
 rtl/led_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/led_ctrl.sv
// Multi-channel LED driver (OFF/ON/BLINK/PWM) with a shared tick prescaler; outputs registered, one-cycle latency.
// Build option: define LED_CTRL_PWM_EN to implement duty registers and PWM mode (otherwise mode 3 acts as OFF).
// No backpressure: config writes are single-cycle strobes that are always accepted.
module led_ctrl #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 32,
    parameter int PRESCALE = 50_000,
    parameter int CH_W     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [1:0]          wr_mode,
    input  logic [CNT_W-1:0]    wr_period,
    input  logic [CNT_W-1:0]    wr_duty,
    output logic [CHANNELS-1:0] led,
    output logic                tick
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_e;

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]     pre_q, pre_d;
    logic                tick_q, tick_d;
    mode_e               mode_q   [CHANNELS];
    mode_e               mode_d   [CHANNELS];
    logic [CNT_W-1:0]    period_q [CHANNELS];
    logic [CNT_W-1:0]    period_d [CHANNELS];
    logic [CNT_W-1:0]    cnt_q    [CHANNELS];
    logic [CNT_W-1:0]    cnt_d    [CHANNELS];
    logic [CHANNELS-1:0] led_q, led_d;
    logic [CHANNELS-1:0] wr_hit;
    logic [CHANNELS-1:0] wrap;

`ifdef LED_CTRL_PWM_EN
    logic [CNT_W-1:0]    duty_q   [CHANNELS];
    logic [CNT_W-1:0]    duty_d   [CHANNELS];
`else
    logic                unused_duty;
    assign unused_duty = ^wr_duty;
`endif

    // With PRESCALE=1 the count is pinned at 0, so tick stays high continuously.
    always_comb begin
        pre_d  = (pre_q == PS_LAST) ? '0 : pre_q + PS_W'(1);
        tick_d = (pre_q == PS_LAST);
    end

    // An out-of-range wr_ch matches no channel and is therefore dropped.
    always_comb begin
        wr_hit = '0;
        wrap   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr_hit[i] = wr_en && (int'(wr_ch) == i);
            wrap[i]   = (period_q[i] == '0) ? 1'b1 : (cnt_q[i] == period_q[i] - CNT_W'(1));
        end
    end

    always_comb begin
        led_d = led_q;
        for (int i = 0; i < CHANNELS; i++) begin
            mode_d[i]   = mode_q[i];
            period_d[i] = period_q[i];
            cnt_d[i]    = cnt_q[i];
`ifdef LED_CTRL_PWM_EN
            duty_d[i]   = duty_q[i];
`endif
            if (wr_hit[i]) begin
                // A write wins over a coincident tick; that tick is simply lost for this channel.
                mode_d[i]   = mode_e'(wr_mode);
                period_d[i] = wr_period;
                cnt_d[i]    = '0;
                led_d[i]    = 1'b0;
`ifdef LED_CTRL_PWM_EN
                duty_d[i]   = wr_duty;
`endif
            end else begin
                if (tick_q) begin
                    cnt_d[i] = wrap[i] ? '0 : cnt_q[i] + CNT_W'(1);
                end
                case (mode_q[i])
                    MODE_ON:    led_d[i] = 1'b1;
                    MODE_BLINK: if (tick_q && wrap[i]) led_d[i] = ~led_q[i];
`ifdef LED_CTRL_PWM_EN
                    MODE_PWM:   if (tick_q) led_d[i] = (cnt_q[i] < duty_q[i]);
`endif
                    default:    led_d[i] = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
            led_q  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i]   <= MODE_OFF;
                period_q[i] <= '0;
                cnt_q[i]    <= '0;
`ifdef LED_CTRL_PWM_EN
                duty_q[i]   <= '0;
`endif
            end
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
            led_q  <= led_d;
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i]   <= mode_d[i];
                period_q[i] <= period_d[i];
                cnt_q[i]    <= cnt_d[i];
`ifdef LED_CTRL_PWM_EN
                duty_q[i]   <= duty_d[i];
`endif
            end
        end
    end

    assign led  = led_q;
    assign tick = tick_q;

endmodule
